// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// DataMemResponder_pkg
// Shared types and constants for the data-memory responder slice.
//   DmemState          : responder FSM states (idle / load wait)
//   WORD_BYTES         : bytes per RAM word
//   MASK_USED_BITS     : byte-enable bits actually honoured (mask[3:0])
//   addr_out_of_range  : word index beyond the RAM depth
// -----------------------------------------------------------------------------
package DataMemResponder_pkg;

    typedef enum logic [0:0] {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } DmemState;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned MASK_USED_BITS = 4;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned MASK_W         = 8;
    localparam int unsigned CNT_W          = 4;

    // True when the word address (byte address / 4) falls past the last RAM word.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                               input int unsigned       depth_words);
        return {2'b00, addr[ADDR_W-1:2]} >= depth_words;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the execute stage (master) and the data
// memory responder (slave).
//   mem_write_in / _addr_in / _data_in / _mask_in : store request
//   mem_read_in / mem_read_addr_in                : load request
//   mem_read_data_out / mem_read_valid_out        : load result
//   stall_out                                     : load pending, hold request
//   err_out                                       : sticky out-of-range flag
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    import DataMemResponder_pkg::*;

    logic              mem_write_in;
    logic [ADDR_W-1:0] mem_write_addr_in;
    logic [DATA_W-1:0] mem_write_data_in;
    logic [MASK_W-1:0] mem_write_mask_in;
    logic              mem_read_in;
    logic [ADDR_W-1:0] mem_read_addr_in;
    logic [DATA_W-1:0] mem_read_data_out;
    logic              mem_read_valid_out;
    logic              stall_out;
    logic              err_out;

    modport master (
        output mem_write_in, mem_write_addr_in, mem_write_data_in, mem_write_mask_in,
        output mem_read_in, mem_read_addr_in,
        input  mem_read_data_out, mem_read_valid_out, stall_out, err_out
    );

    modport slave (
        input  mem_write_in, mem_write_addr_in, mem_write_data_in, mem_write_mask_in,
        input  mem_read_in, mem_read_addr_in,
        output mem_read_data_out, mem_read_valid_out, stall_out, err_out
    );

endinterface

// File: rtl/data_mem_responder_ram_be.sv
// -----------------------------------------------------------------------------
// dmem_ram_be
// Byte-enabled word RAM, one write port and one read port.
//   clk   : clock
//   we    : write enable; byte i written when be[i] is set
//   waddr : write word index
//   wdata : write data, lane-aligned
//   be    : byte enables [3:0]
//   re    : read enable; rdata holds its value while re is low
//   raddr : read word index
//   rdata : synchronous read data, returns the pre-write word on a same-edge
//           read/write to the same index
// -----------------------------------------------------------------------------
module dmem_ram_be
    import DataMemResponder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [MASK_USED_BITS-1:0] be,
    input  logic                      re,
    input  logic [IDX_W-1:0]          raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset so it maps onto block RAM; its contents are
    // only defined once written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(MASK_USED_BITS); i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        // NOTE: non-blocking assignment makes this read see the old word even
        // when the write above targets the same index on this edge.
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Far end of the execute stage's store/load interface. Commits byte-masked
// stores immediately and returns full aligned load words after WAIT_CYCLES
// wait states, holding stall_out high while a load is pending.
//   clk    : clock
//   reset  : synchronous, active-low reset
//   bus    : data_mem_responder_if.slave (requests in, load data/stall/err out)
// Parameters:
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two)
//   WAIT_CYCLES : extra load latency, 0..15
// Build option:
//   DMEM_RANGE_CHECK_EN : out-of-range requests set sticky err_out, stores are
//                         dropped and loads return zero. Without it addresses
//                         wrap modulo the depth and err_out is 0.
// -----------------------------------------------------------------------------
module data_mem_responder
    import DataMemResponder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned      IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam bit               HAS_WAIT  = (WAIT_CYCLES != 0);

    DmemState          state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  pend_idx;
    logic              pend_oor;
    logic              valid_q;
    logic              stall_q;
    logic              zero_q;     // present 0 instead of RAM data (reset / out-of-range load)

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_oor;
    logic              rd_oor;
    logic              wr_go;
    logic              rd_go;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Byte offset bits and bits above the index only matter to the range check.
    assign wr_idx = bus.mem_write_addr_in[2 +: IDX_W];
    assign rd_idx = bus.mem_read_addr_in[2 +: IDX_W];

`ifdef DMEM_RANGE_CHECK_EN
    assign wr_oor = addr_out_of_range(bus.mem_write_addr_in, DEPTH_WORDS);
    assign rd_oor = addr_out_of_range(bus.mem_read_addr_in, DEPTH_WORDS);
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{bus.mem_write_addr_in, bus.mem_read_addr_in,
                           bus.mem_write_mask_in[MASK_W-1:MASK_USED_BITS]};

    // Requests are only accepted in IDLE; in WAIT the initiator holds them.
    assign wr_go = (state == DMEM_IDLE) && bus.mem_write_in;
    assign rd_go = (state == DMEM_IDLE) && bus.mem_read_in;

    // NOTE: every output of this block gets a default first so no latch is
    // inferred on the paths that do not assign it.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = rd_idx;
        if (reset && wr_go && !wr_oor) begin
            ram_we = 1'b1;
        end
        if (HAS_WAIT) begin
            // Read on the last wait edge so the word lands with the valid pulse.
            ram_raddr = pend_idx;
            ram_re    = (state == DMEM_WAIT) && (cnt == CNT_W'(1));
        end else begin
            ram_re    = rd_go;
        end
    end

    dmem_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_idx),
        .wdata (bus.mem_write_data_in),
        .be    (bus.mem_write_mask_in[MASK_USED_BITS-1:0]),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= DMEM_IDLE;
            cnt      <= '0;
            pend_idx <= '0;
            pend_oor <= 1'b0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (rd_go) begin
                        if (HAS_WAIT) begin
                            state    <= DMEM_WAIT;
                            cnt      <= WAIT_INIT;
                            pend_idx <= rd_idx;
                            pend_oor <= rd_oor;
                            stall_q  <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                            zero_q  <= rd_oor;
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DMEM_IDLE;
                        valid_q <= 1'b1;
                        stall_q <= 1'b0;
                        zero_q  <= pend_oor;
                    end
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((wr_go && wr_oor) || (rd_go && rd_oor)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_out = err_q;
`else
    assign bus.err_out = 1'b0;
`endif

    assign bus.mem_read_data_out  = zero_q ? '0 : ram_rdata;
    assign bus.mem_read_valid_out = valid_q;
    assign bus.stall_out          = stall_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Drives two responders side by side: one with no wait states and one with
// three. A word-array model of each RAM supplies expected load data; the
// expected timing comes straight from the latency rules (result one cycle
// after the request, or WAIT_CYCLES stall cycles then the result).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
    import DataMemResponder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WAIT3 = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder_if b0 ();
    data_mem_responder_if b3 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one word array per DUT plus the expected sticky error.
    logic [31:0] ref_mem [2][DEPTH];
    logic        ref_err [2];
    logic [31:0] last0;
    logic [31:0] last3;

    int pool [8] = '{0, 1, 2, 3, 16, 32, 100, 1023};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a / 4) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] ref_load(input int d, input logic [31:0] a);
        return ref_oor(a) ? 32'h0 : ref_mem[d][widx(a)];
    endfunction

    task automatic ref_store(input int d, input logic [31:0] a, input logic [31:0] data,
                             input logic [7:0] mask);
        if (ref_oor(a)) begin
            ref_err[d] = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) ref_mem[d][widx(a)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [31:0] p;
        p = pool[$urandom_range(0, 7)];
        a = {20'h0, p[9:0], 2'($urandom)};
        if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom) | 20'h1;
        return a;
    endfunction

    task automatic clear_inputs();
        b0.mem_write_in = 1'b0; b0.mem_read_in = 1'b0;
        b3.mem_write_in = 1'b0; b3.mem_read_in = 1'b0;
    endtask

    // One cycle on the zero-wait DUT: optional store and/or load, then check.
    task automatic op0(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [7:0] wm, input logic rd, input logic [31:0] ra);
        logic [31:0] exp_rd;
        exp_rd = 32'h0;
        b0.mem_write_in      = wr;
        b0.mem_write_addr_in = wa;
        b0.mem_write_data_in = wd;
        b0.mem_write_mask_in = wm;
        b0.mem_read_in       = rd;
        b0.mem_read_addr_in  = ra;
        if (rd) begin
            exp_rd = ref_load(0, ra);   // sampled before the store: read-before-write
            if (ref_oor(ra)) ref_err[0] = 1'b1;
        end
        if (wr) ref_store(0, wa, wd, wm);
        tick();
        b0.mem_write_in = 1'b0;
        b0.mem_read_in  = 1'b0;
        if (rd) last0 = exp_rd;
        check("d0_valid", b0.mem_read_valid_out, rd);
        check("d0_data", b0.mem_read_data_out, last0);
        check("d0_stall", b0.stall_out, 1'b0);
        check("d0_err", b0.err_out, ref_err[0]);
    endtask

    // Full load on the three-wait DUT; optionally present ignored requests
    // while the load is pending.
    task automatic load3(input logic [31:0] ra, input bit intrude);
        logic [31:0] exp_rd;
        exp_rd = ref_load(1, ra);
        if (ref_oor(ra)) ref_err[1] = 1'b1;
        b3.mem_read_in      = 1'b1;
        b3.mem_read_addr_in = ra;
        tick();
        b3.mem_read_in = 1'b0;
        for (int i = 0; i < WAIT3; i++) begin
            check("d3_stall_wait", b3.stall_out, 1'b1);
            check("d3_valid_wait", b3.mem_read_valid_out, 1'b0);
            check("d3_data_hold", b3.mem_read_data_out, last3);
            if (intrude && i < 2) begin
                b3.mem_read_in       = 1'b1;
                b3.mem_read_addr_in  = 32'h0000_0080;
                b3.mem_write_in      = 1'b1;
                b3.mem_write_addr_in = 32'h0000_0080;
                b3.mem_write_data_in = ~ref_mem[1][32];
                b3.mem_write_mask_in = 8'h0F;
            end else begin
                b3.mem_read_in  = 1'b0;
                b3.mem_write_in = 1'b0;
            end
            tick();
        end
        clear_inputs();
        last3 = exp_rd;
        check("d3_valid", b3.mem_read_valid_out, 1'b1);
        check("d3_data", b3.mem_read_data_out, last3);
        check("d3_stall_done", b3.stall_out, 1'b0);
        check("d3_err", b3.err_out, ref_err[1]);
        tick();
        check("d3_valid_after", b3.mem_read_valid_out, 1'b0);
        check("d3_stall_after", b3.stall_out, 1'b0);
        check("d3_data_after", b3.mem_read_data_out, last3);
    endtask

    task automatic check_reset_state();
        check("rst_d0_valid", b0.mem_read_valid_out, 1'b0);
        check("rst_d0_data", b0.mem_read_data_out, 32'h0);
        check("rst_d0_stall", b0.stall_out, 1'b0);
        check("rst_d0_err", b0.err_out, 1'b0);
        check("rst_d3_valid", b3.mem_read_valid_out, 1'b0);
        check("rst_d3_data", b3.mem_read_data_out, 32'h0);
        check("rst_d3_stall", b3.stall_out, 1'b0);
        check("rst_d3_err", b3.err_out, 1'b0);
    endtask

    initial begin
        logic [31:0] wd;
        logic [31:0] a;
        bit          wr;
        bit          rd;

        clear_inputs();
        b0.mem_write_addr_in = '0; b0.mem_write_data_in = '0; b0.mem_write_mask_in = '0;
        b0.mem_read_addr_in  = '0;
        b3.mem_write_addr_in = '0; b3.mem_write_data_in = '0; b3.mem_write_mask_in = '0;
        b3.mem_read_addr_in  = '0;
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;
        last0 = 32'h0; last3 = 32'h0;

        // Reset state
        repeat (3) tick();
        check_reset_state();
        reset = 1'b1;
        tick();

        // Give every pool word a known value in both RAMs.
        foreach (pool[k]) begin
            wd = $urandom;
            a  = 32'(pool[k]) * 4;
            b0.mem_write_in = 1'b1; b0.mem_write_addr_in = a;
            b0.mem_write_data_in = wd; b0.mem_write_mask_in = 8'h0F;
            b3.mem_write_in = 1'b1; b3.mem_write_addr_in = a;
            b3.mem_write_data_in = wd ^ 32'h5A5A_5A5A; b3.mem_write_mask_in = 8'h0F;
            ref_store(0, a, wd, 8'h0F);
            ref_store(1, a, wd ^ 32'h5A5A_5A5A, 8'h0F);
            tick();
            clear_inputs();
            check("fill_d3_stall", b3.stall_out, 1'b0);
        end

        // Full store then load, no wait states
        op0(1'b1, 32'h40, 32'hDEAD_BEEF, 8'h0F, 1'b0, 32'h0);
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h40);
        check("d0_deadbeef", b0.mem_read_data_out, 32'hDEAD_BEEF);
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);

        // Byte-lane store; upper mask bits are ignored
        op0(1'b1, 32'h40, 32'h0000_00AA, 8'h01, 1'b0, 32'h0);
        op0(1'b1, 32'h40, 32'hFFFF_FFFF, 8'hF0, 1'b1, 32'h40);
        check("d0_deadbeaa", b0.mem_read_data_out, 32'hDEAD_BEAA);
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h43);
        check("d0_mask_f0", b0.mem_read_data_out, 32'hDEAD_BEAA);

        // Same-cycle store and load: old word first, new word next
        op0(1'b1, 32'h80, 32'h2222_2222, 8'h0F, 1'b0, 32'h0);
        op0(1'b1, 32'h80, 32'h1111_1111, 8'h0F, 1'b1, 32'h80);
        check("d0_rbw_old", b0.mem_read_data_out, 32'h2222_2222);
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h80);
        check("d0_rbw_new", b0.mem_read_data_out, 32'h1111_1111);

        // Address past the depth: wraps to word 0, or zero plus error
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b1, 32'h1000);
`ifdef DMEM_RANGE_CHECK_EN
        check("d0_oor_data", b0.mem_read_data_out, 32'h0);
        check("d0_oor_err", b0.err_out, 1'b1);
`else
        check("d0_wrap_data", b0.mem_read_data_out, ref_mem[0][0]);
`endif
        op0(1'b0, 32'h0, 32'h0, 8'h00, 1'b0, 32'h0);

        // Three wait states, with requests presented during the wait
        load3(32'h40, 1'b1);
        load3(32'h80, 1'b0);

        // Reset while a load is pending
        b3.mem_read_in = 1'b1; b3.mem_read_addr_in = 32'h40;
        tick();
        clear_inputs();
        check("rw_stall", b3.stall_out, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;
        last0 = 32'h0; last3 = 32'h0;
        check_reset_state();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rw_no_valid", b3.mem_read_valid_out, 1'b0);
            check("rw_no_stall", b3.stall_out, 1'b0);
        end
        load3(32'h40, 1'b0);

        // Randomized traffic on the zero-wait DUT
        for (int n = 0; n < 300; n++) begin
            wr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 0);
            op0(wr, rand_addr(), $urandom, 8'($urandom), rd, rand_addr());
        end

        // Randomized loads on the wait-state DUT
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            load3(rand_addr(), $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
